// File: rtl/jtag_load_ctrl.sv
// Program-load sequencer: streams DEPTH data words then DEPTH instruction words (highest
// address first) into the memories, then releases the core. Optional macro: LOAD_CHECKSUM_EN.
module jtag_load_ctrl #(
   parameter int W     = 32,
   parameter int DEPTH = 512,
   parameter int AW    = 9
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          jen,
   input  logic [W-1:0]  jin,
   output logic          dmem_we,
   output logic          imem_we,
   output logic [AW-1:0] mem_addr,
   output logic [W-1:0]  mem_wdata,
   output logic          cpu_rst_n,
   output logic          load_done,
   output logic          overflow,
   output logic [W-1:0]  jout
);

   localparam int CW = AW + 1;
   localparam logic [CW-1:0] LAST_D = CW'(DEPTH - 1);
   localparam logic [CW-1:0] LAST_I = CW'(2 * DEPTH - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD_D,
      S_LOAD_I,
      S_DONE,
      S_RUN
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            ovf_q, ovf_d;
   logic            dwe_q, dwe_d;
   logic            iwe_q, iwe_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic [W-1:0]    wdata_q, wdata_d;
   logic [CW-1:0]   k;
   logic            accept;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
         dwe_q   <= 1'b0;
         iwe_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
         dwe_q   <= dwe_d;
         iwe_q   <= iwe_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      dwe_d   = 1'b0;
      iwe_d   = 1'b0;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      k       = cnt_q;
      accept  = 1'b0;

      case (state_q)
         S_IDLE, S_RUN: begin
            // A word offered here always starts a fresh image at word 0.
            if (jen) begin
               accept = 1'b1;
               k      = '0;
               ovf_d  = 1'b0;
            end
         end
         S_LOAD_D, S_LOAD_I: begin
            if (jen) accept = 1'b1;
         end
         S_DONE: begin
            if (jen) ovf_d = 1'b1;
            else     state_d = S_RUN;
         end
         default: state_d = S_IDLE;
      endcase

      if (accept) begin
         wdata_d = jin;
         cnt_d   = k + CW'(1);
         if (k <= LAST_D) begin
            dwe_d  = 1'b1;
            addr_d = AW'(LAST_D - k);
         end else begin
            iwe_d  = 1'b1;
            addr_d = AW'(LAST_I - k);
         end
         // Checking LAST_D second covers DEPTH=1, where word 0 leads straight to LOAD_I.
         if (k == LAST_I)      state_d = S_DONE;
         else if (k >= LAST_D) state_d = S_LOAD_I;
         else                  state_d = S_LOAD_D;
      end
   end

   assign dmem_we   = dwe_q;
   assign imem_we   = iwe_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign cpu_rst_n = (state_q == S_RUN);
   assign load_done = (state_q == S_RUN);
   assign overflow  = ovf_q;

`ifdef LOAD_CHECKSUM_EN
   logic [W-1:0] sum_q, sum_d;
   logic         start;

   always_comb begin
      start = accept && ((state_q == S_IDLE) || (state_q == S_RUN));
      sum_d = sum_q;
      if (accept) sum_d = start ? jin : (sum_q + jin);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) sum_q <= '0;
      else        sum_q <= sum_d;
   end

   assign jout = ((state_q == S_DONE) || (state_q == S_RUN)) ? sum_q : '0;
`else
   assign jout = '0;
`endif

endmodule

// File: tb/tb_jtag_load_ctrl.sv
// Randomized bench for jtag_load_ctrl against a word-count based model of the load protocol.
module tb_jtag_load_ctrl;

   localparam int W     = 32;
   localparam int DEPTH = 512;
   localparam int AW    = 9;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          jen = 1'b0;
   logic [W-1:0]  jin = '0;
   logic          dmem_we, imem_we, cpu_rst_n, load_done, overflow;
   logic [AW-1:0] mem_addr;
   logic [W-1:0]  mem_wdata, jout;

   int n_tests = 0;
   int n_fail  = 0;

   jtag_load_ctrl #(.W(W), .DEPTH(DEPTH), .AW(AW)) dut (
      .clk(clk), .rst_n(rst_n), .jen(jen), .jin(jin),
      .dmem_we(dmem_we), .imem_we(imem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .cpu_rst_n(cpu_rst_n), .load_done(load_done), .overflow(overflow), .jout(jout)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         if (n_fail <= 40) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: an image is a count of words accepted so far; it is released once complete and jen drops.
   int            m_n = 0;
   bit            m_started = 0, m_rel = 0, m_ovf = 0;
   logic [W-1:0]  m_sum = '0;
   bit            e_dwe = 0, e_iwe = 0;
   int            e_addr = 0;
   logic [W-1:0]  e_wdata = '0;
   logic [W-1:0]  m_dmem [DEPTH];
   logic [W-1:0]  m_imem [DEPTH];
   logic [W-1:0]  s_dmem [DEPTH];
   logic [W-1:0]  s_imem [DEPTH];

   always @(posedge clk) begin
      e_dwe <= 0;
      e_iwe <= 0;
      if (!rst_n) begin
         m_n <= 0; m_started <= 0; m_rel <= 0; m_ovf <= 0; m_sum <= '0;
      end else if (jen) begin
         if (!m_started || m_rel) begin
            m_n <= 1; m_sum <= jin; m_ovf <= 0; m_rel <= 0; m_started <= 1;
            e_dwe <= 1; e_addr <= DEPTH - 1; e_wdata <= jin;
            m_dmem[DEPTH-1] <= jin;
         end else if (m_n < 2 * DEPTH) begin
            m_n <= m_n + 1; m_sum <= m_sum + jin; e_wdata <= jin;
            if (m_n < DEPTH) begin
               e_dwe <= 1; e_addr <= DEPTH - 1 - m_n; m_dmem[DEPTH-1-m_n] <= jin;
            end else begin
               e_iwe <= 1; e_addr <= 2 * DEPTH - 1 - m_n; m_imem[2*DEPTH-1-m_n] <= jin;
            end
         end else begin
            m_ovf <= 1;
         end
      end else if (m_started && m_n == 2 * DEPTH) begin
         m_rel <= 1;
      end
   end

   function automatic logic [W-1:0] exp_jout();
`ifdef LOAD_CHECKSUM_EN
      return (m_started && m_n == 2 * DEPTH) ? m_sum : '0;
`else
      return '0;
`endif
   endfunction

   always @(negedge clk) begin
      check("dmem_we", dmem_we, e_dwe);
      check("imem_we", imem_we, e_iwe);
      if (e_dwe || e_iwe) begin
         check("mem_addr", mem_addr, e_addr);
         check("mem_wdata", mem_wdata, e_wdata);
      end
      check("cpu_rst_n", cpu_rst_n, m_rel);
      check("load_done", load_done, m_rel);
      check("overflow", overflow, m_ovf);
      check("jout", jout, exp_jout());
      if (dmem_we === 1'b1) s_dmem[mem_addr] = mem_wdata;
      if (imem_we === 1'b1) s_imem[mem_addr] = mem_wdata;
   end

   task automatic cyc(input logic r, input logic e, input logic [W-1:0] d);
      rst_n = r; jen = e; jin = d;
      @(posedge clk);
      #1;
   endtask

   task automatic word(input logic [W-1:0] d, input int pause_pct);
      while ($urandom_range(99) < pause_pct) cyc(1'b1, 1'b0, $urandom);
      cyc(1'b1, 1'b1, d);
   endtask

   task automatic check_image_literals();
      check("dmem[511]", s_dmem[511], 0);
      check("dmem[0]", s_dmem[0], 511);
      check("imem[511]", s_imem[511], 512);
      check("imem[0]", s_imem[0], 1023);
   endtask

   initial begin
      // Reset, jen low
      cyc(1'b0, 1'b0, '0);
      cyc(1'b0, 1'b0, '0);
      check("rst_outputs", {dmem_we, imem_we, cpu_rst_n, load_done, overflow}, 0);
      check("rst_addr_data", {mem_addr, mem_wdata}, 0);
      check("rst_jout", jout, 0);
      cyc(1'b1, 1'b0, '0);

      // Full image, jin = k
      for (int k = 0; k < 2 * DEPTH; k++) begin
         cyc(1'b1, 1'b1, W'(k));
         if (k == 0) check("first_addr", {dmem_we, mem_addr}, {1'b1, 9'd511});
      end
      check("done_cpu_rst", {cpu_rst_n, load_done}, 0);
`ifdef LOAD_CHECKSUM_EN
      check("checksum", jout, 523776);
`else
      check("checksum_off", jout, 0);
`endif
      cyc(1'b1, 1'b0, '0);
      check("run_flags", {load_done, cpu_rst_n, overflow}, 3'b110);
      check_image_literals();

      // New image from RUN with a 5-cycle gap after word 300 and 2 overflow words
      for (int k = 0; k < 2 * DEPTH + 2; k++) begin
         cyc(1'b1, 1'b1, W'(k));
         if (k == 301) check("resume_addr", {dmem_we, mem_addr}, {1'b1, 9'd210});
         if (k == 300) begin
            for (int g = 0; g < 5; g++) begin
               cyc(1'b1, 1'b0, $urandom);
               check("gap_strobes", {dmem_we, imem_we}, 0);
            end
         end
      end
      check("overflow_set", overflow, 1);
      cyc(1'b1, 1'b0, '0);
      check("overflow_sticky_run", {overflow, load_done}, 2'b11);
      check_image_literals();
      cyc(1'b1, 1'b1, $urandom);
      check("restart_flags", {overflow, load_done, cpu_rst_n}, 0);
      check("restart_write", {dmem_we, mem_addr}, {1'b1, 9'd511});

      // Partial random image, then reset (with jen high) at word 700
      for (int k = 1; k < 700; k++) word($urandom, 15);
      cyc(1'b0, 1'b1, $urandom);
      check("midrst", {cpu_rst_n, dmem_we, imem_we, load_done}, 0);
      cyc(1'b1, 1'b0, '0);

      // Random reload with random pauses
      for (int k = 0; k < 2 * DEPTH; k++) begin
         word($urandom, 10);
         if (k == 0) check("reload_addr", {dmem_we, mem_addr}, {1'b1, 9'd511});
      end
      cyc(1'b1, 1'b0, '0);
      check("reload_run", {load_done, cpu_rst_n, overflow}, 3'b110);
      for (int i = 0; i < DEPTH; i++) begin
         check("dmem_img", s_dmem[i], m_dmem[i]);
         check("imem_img", s_imem[i], m_imem[i]);
      end
      cyc(1'b1, 1'b0, '0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
